// File: rtl/lvds_rx_pkg.sv
// Shared state encoding, default parameters and output-decode helpers for the LVDS receiver bring-up controller.
package lvds_rx_pkg;

    localparam int NCH_DEF                = 4;
    localparam int PLL_RST_CYCLES_DEF     = 8;
    localparam int LOCK_STABLE_CYCLES_DEF = 20;
    localparam int TIMEOUT_CYCLES_DEF     = 1024;
    localparam int MAX_RETRIES_DEF        = 3;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_PLL_RST     = 4'd1,
        ST_WAIT_LOCK   = 4'd2,
        ST_LOCK_STABLE = 4'd3,
        ST_WAIT_DPA    = 4'd4,
        ST_FIFO_RST    = 4'd5,
        ST_CDA_RST     = 4'd6,
        ST_READY       = 4'd7,
        ST_FAIL        = 4'd8
    } state_t;

    // States in which the LVDS PLL is held in reset.
    function automatic logic pll_held(state_t s);
        return (s == ST_IDLE) || (s == ST_PLL_RST) || (s == ST_FAIL);
    endfunction

    // The receivers stay in reset until the PLL lock has proven stable.
    function automatic logic rx_held(state_t s);
        return pll_held(s) || (s == ST_WAIT_LOCK) || (s == ST_LOCK_STABLE);
    endfunction

endpackage

// File: rtl/lvds_rx_bringup_ctrl_sync2.sv
// Two-flop synchronizer for asynchronous lock status, cleared by async active-low reset.
// Latency: 2 cycles; no backpressure.
module lvds_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             inclock,
    input  logic             areset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge inclock or negedge areset_n) begin
        if (!areset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lvds_rx_bringup_ctrl.sv
// LVDS receiver bring-up sequencer: PLL reset, lock qualification, DPA wait, FIFO/CDA reset pulses, retry/fail.
// Latency: outputs registered from the next state; no backpressure, start is only honoured in IDLE and FAIL.
module lvds_rx_bringup_ctrl
    import lvds_rx_pkg::*;
#(
    parameter int NCH                = NCH_DEF,
    parameter int PLL_RST_CYCLES     = PLL_RST_CYCLES_DEF,
    parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF,
    parameter int MAX_RETRIES        = MAX_RETRIES_DEF
) (
    input  logic           inclock,
    input  logic           areset_n,
    input  logic           start,
    input  logic           rx_locked,
    input  logic [NCH-1:0] rx_dpa_locked,
    output logic           pll_areset,
    output logic [NCH-1:0] rx_reset,
    output logic [NCH-1:0] rx_fifo_reset,
    output logic [NCH-1:0] rx_cda_reset,
    output logic           link_ready,
    output logic           init_fail,
    output logic [1:0]     retry_cnt,
    output logic [3:0]     state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] PLL_LAST    = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    state_t         st;
    state_t         nxt;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_inc;
    logic [1:0]     retry_nxt;
    logic           fail_attempt;
    logic           lock_s;
    logic [NCH-1:0] dpa_s;

    lvds_sync2 #(.WIDTH(1)) u_sync_lock (
        .inclock  (inclock),
        .areset_n (areset_n),
        .d        (rx_locked),
        .q        (lock_s)
    );

    lvds_sync2 #(.WIDTH(NCH)) u_sync_dpa (
        .inclock  (inclock),
        .areset_n (areset_n),
        .d        (rx_dpa_locked),
        .q        (dpa_s)
    );

    assign timer_inc = (timer == TIMER_MAX) ? timer : timer + 1'b1;

    always_comb begin
        nxt          = st;
        retry_nxt    = retry_cnt;
        fail_attempt = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (start) begin
                    nxt       = ST_PLL_RST;
                    retry_nxt = '0;
                end
            end
            ST_PLL_RST: begin
                if (timer == PLL_LAST) nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (timer == TO_LAST) fail_attempt = 1'b1;
                else if (lock_s)      nxt = ST_LOCK_STABLE;
            end
            ST_LOCK_STABLE: begin
                // The timer doubles as the consecutive-high counter; any low sample restarts qualification.
                if (!lock_s)                 nxt = ST_WAIT_LOCK;
                else if (timer == STABLE_LAST) nxt = ST_WAIT_DPA;
            end
            ST_WAIT_DPA: begin
                // Timeout and lock loss collapse into one failed attempt.
                if (!lock_s || (timer == TO_LAST)) fail_attempt = 1'b1;
                else if (&dpa_s)                   nxt = ST_FIFO_RST;
            end
            ST_FIFO_RST: begin
                if (!lock_s) fail_attempt = 1'b1;
                else         nxt = ST_CDA_RST;
            end
            ST_CDA_RST: begin
                if (!lock_s) fail_attempt = 1'b1;
                else         nxt = ST_READY;
            end
            ST_READY: begin
                if (!lock_s) begin
                    nxt       = ST_PLL_RST;
                    retry_nxt = '0;
                end
            end
            ST_FAIL: begin
                if (start) begin
                    nxt       = ST_PLL_RST;
                    retry_nxt = '0;
                end
            end
            default: nxt = ST_IDLE;
        endcase

        if (fail_attempt) begin
            retry_nxt = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
            nxt       = (int'(retry_cnt) + 1 >= MAX_RETRIES) ? ST_FAIL : ST_PLL_RST;
        end
    end

    // Outputs are decoded from the next state so they change in the same cycle as the state register.
    always_ff @(posedge inclock or negedge areset_n) begin
        if (!areset_n) begin
            st            <= ST_IDLE;
            timer         <= '0;
            retry_cnt     <= '0;
            pll_areset    <= 1'b1;
            rx_reset      <= '1;
            rx_fifo_reset <= '0;
            rx_cda_reset  <= '0;
            link_ready    <= 1'b0;
            init_fail     <= 1'b0;
        end else begin
            st            <= nxt;
            timer         <= (nxt != st) ? '0 : timer_inc;
            retry_cnt     <= retry_nxt;
            pll_areset    <= pll_held(nxt);
            rx_reset      <= {NCH{rx_held(nxt)}};
            rx_fifo_reset <= {NCH{nxt == ST_FIFO_RST}};
            rx_cda_reset  <= {NCH{nxt == ST_CDA_RST}};
            link_ready    <= (nxt == ST_READY);
            init_fail     <= (nxt == ST_FAIL);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_lvds_rx_bringup_ctrl.sv
// Scoreboard bench for lvds_rx_bringup_ctrl: expected state transitions (with outputs and dwell times)
// are queued by the stimulus and checked by a monitor whenever the DUT state changes.
`timescale 1ns/1ps
module tb_lvds_rx_bringup_ctrl;
    import lvds_rx_pkg::*;

    logic       inclock = 1'b0;
    logic       areset_n = 1'b0;
    logic       start = 1'b0;
    logic       rx_locked = 1'b0;
    logic [3:0] rx_dpa_locked = 4'h0;
    logic       pll_areset;
    logic [3:0] rx_reset;
    logic [3:0] rx_fifo_reset;
    logic [3:0] rx_cda_reset;
    logic       link_ready;
    logic       init_fail;
    logic [1:0] retry_cnt;
    logic [3:0] state;

    lvds_rx_bringup_ctrl dut (
        .inclock       (inclock),
        .areset_n      (areset_n),
        .start         (start),
        .rx_locked     (rx_locked),
        .rx_dpa_locked (rx_dpa_locked),
        .pll_areset    (pll_areset),
        .rx_reset      (rx_reset),
        .rx_fifo_reset (rx_fifo_reset),
        .rx_cda_reset  (rx_cda_reset),
        .link_ready    (link_ready),
        .init_fail     (init_fail),
        .retry_cnt     (retry_cnt),
        .state         (state)
    );

    always #5 inclock = ~inclock;

    typedef struct {
        logic [3:0] st;
        logic [1:0] r;
        int         dwell;   // cycles spent in the state being left; -1 = not checked
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         vectors = 0;
    int         miscompares = 0;
    int         t = 0;
    logic [3:0] prev_st = 4'd0;
    int         dwell = 0;
    logic [20:0] act;

    assign act = {state, pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset, link_ready, init_fail, retry_cnt};

    // Output table: {pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset, link_ready, init_fail, retry_cnt}
    function automatic logic [16:0] outs_for(input logic [3:0] s, input logic [1:0] r);
        logic       pll;
        logic [3:0] rr, ff, cc;
        logic       lk, fl;
        pll = 1'b0; rr = 4'h0; ff = 4'h0; cc = 4'h0; lk = 1'b0; fl = 1'b0;
        case (s)
            4'd0, 4'd1:  begin pll = 1'b1; rr = 4'hF; end
            4'd8:        begin pll = 1'b1; rr = 4'hF; fl = 1'b1; end
            4'd2, 4'd3:  rr = 4'hF;
            4'd5:        ff = 4'hF;
            4'd6:        cc = 4'hF;
            4'd7:        lk = 1'b1;
            default: ;
        endcase
        return {pll, rr, ff, cc, lk, fl, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
        vectors++;
        if (a !== x) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, a, x, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] s, input logic [1:0] r, input int d);
        exp_t n;
        n.st = s; n.r = r; n.dwell = d;
        sb.push_back(n);
    endtask

    task automatic upto(input int k);
        while (t < k - 1) begin
            @(negedge inclock);
            t++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge inclock);
            n++;
        end
        chk("expected transitions all seen", sb.size(), 0);
    endtask

    // Monitor: every state change is an output event checked against the scoreboard head.
    always @(negedge inclock) begin
        if (!areset_n) begin
            prev_st = 4'd0;
            dwell   = 0;
        end else if (state !== prev_st) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected transition: state %0d -> %0d, expected none (t=%0t)", prev_st, state, $time);
            end else begin
                e = sb.pop_front();
                chk($sformatf("state/outputs entering %0d", e.st), {11'b0, act}, {11'b0, e.st, outs_for(e.st, e.r)});
                if (e.dwell >= 0)
                    chk($sformatf("dwell in %0d before %0d", prev_st, e.st), dwell, e.dwell);
            end
            prev_st = state;
            dwell   = 1;
        end else begin
            dwell++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge inclock);
        #1 chk("reset outputs", {11'b0, act}, {11'b0, 4'd0, outs_for(4'd0, 2'd0)});
        @(negedge inclock);
        areset_n = 1'b1;

        // 1: nominal bring-up; start during WAIT_DPA must be ignored
        t = 0;
        push_exp(ST_PLL_RST,     2'd0, -1);
        push_exp(ST_WAIT_LOCK,   2'd0, 8);
        push_exp(ST_LOCK_STABLE, 2'd0, 14);
        push_exp(ST_WAIT_DPA,    2'd0, 20);
        push_exp(ST_FIFO_RST,    2'd0, 50);
        push_exp(ST_CDA_RST,     2'd0, 1);
        push_exp(ST_READY,       2'd0, 1);
        upto(10);  start = 1'b1;
        upto(11);  start = 1'b0;
        upto(30);  rx_locked = 1'b1;
        upto(70);  start = 1'b1;
        upto(71);  start = 1'b0;
        upto(100); rx_dpa_locked = 4'hF;
        drain(200);
        repeat (30) @(negedge inclock);
        chk("link_ready held", {link_ready, state}, {1'b1, 4'd7});

        // 4 + 2: lock loss in READY, then a one-cycle glitch during LOCK_STABLE
        t = 0;
        push_exp(ST_PLL_RST,     2'd0, -1);
        push_exp(ST_WAIT_LOCK,   2'd0, 8);
        push_exp(ST_LOCK_STABLE, 2'd0, 11);
        push_exp(ST_WAIT_LOCK,   2'd0, 12);
        push_exp(ST_LOCK_STABLE, 2'd0, 1);
        push_exp(ST_WAIT_DPA,    2'd0, 20);
        push_exp(ST_FIFO_RST,    2'd0, 1);
        push_exp(ST_CDA_RST,     2'd0, 1);
        push_exp(ST_READY,       2'd0, 1);
        upto(1);  rx_locked = 1'b0;
        upto(3);  chk("link_ready before synced loss", link_ready, 1'b1);
        upto(4);  chk("link_ready/pll_areset after loss", {link_ready, pll_areset}, 2'b01);
        upto(20); rx_locked = 1'b1;
        upto(32); rx_locked = 1'b0;
        upto(33); rx_locked = 1'b1;
        drain(200);

        // 3: DPA never locks -> three timeouts -> FAIL, then start recovers
        t = 0;
        push_exp(ST_PLL_RST,     2'd0, -1);
        push_exp(ST_WAIT_LOCK,   2'd0, 8);
        push_exp(ST_LOCK_STABLE, 2'd0, 1);
        push_exp(ST_WAIT_DPA,    2'd0, 20);
        push_exp(ST_PLL_RST,     2'd1, 1024);
        push_exp(ST_WAIT_LOCK,   2'd1, 8);
        push_exp(ST_LOCK_STABLE, 2'd1, 1);
        push_exp(ST_WAIT_DPA,    2'd1, 20);
        push_exp(ST_PLL_RST,     2'd2, 1024);
        push_exp(ST_WAIT_LOCK,   2'd2, 8);
        push_exp(ST_LOCK_STABLE, 2'd2, 1);
        push_exp(ST_WAIT_DPA,    2'd2, 20);
        push_exp(ST_FAIL,        2'd3, 1024);
        push_exp(ST_PLL_RST,     2'd0, 38);
        push_exp(ST_WAIT_LOCK,   2'd0, 8);
        push_exp(ST_LOCK_STABLE, 2'd0, 1);
        push_exp(ST_WAIT_DPA,    2'd0, 20);
        push_exp(ST_FIFO_RST,    2'd0, 1);
        push_exp(ST_CDA_RST,     2'd0, 1);
        push_exp(ST_READY,       2'd0, 1);
        upto(1);    begin rx_locked = 1'b0; rx_dpa_locked = 4'h7; end
        upto(5);    rx_locked = 1'b1;
        upto(100);  start = 1'b1;
        upto(101);  start = 1'b0;
        upto(3200);
        chk("FAIL held", {init_fail, pll_areset, retry_cnt, state}, {1'b1, 1'b1, 2'd3, 4'd8});
        start = 1'b1;
        rx_dpa_locked = 4'hF;
        upto(3201); start = 1'b0;
        drain(200);

        // 5: asynchronous reset during FIFO_RST
        t = 0;
        push_exp(ST_PLL_RST,     2'd0, -1);
        push_exp(ST_WAIT_LOCK,   2'd0, 8);
        push_exp(ST_LOCK_STABLE, 2'd0, 1);
        push_exp(ST_WAIT_DPA,    2'd0, 20);
        push_exp(ST_FIFO_RST,    2'd0, 1);
        upto(1);  rx_locked = 1'b0;
        upto(5);  rx_locked = 1'b1;
        upto(34);
        #1 chk("fifo pulse before reset", rx_fifo_reset, 4'hF);
        areset_n = 1'b0;
        #1 chk("async reset mid-pulse", {11'b0, act}, {11'b0, 4'd0, outs_for(4'd0, 2'd0)});
        chk("scoreboard empty at reset", sb.size(), 0);
        repeat (2) @(negedge inclock);
        areset_n = 1'b1;
        repeat (10) @(negedge inclock);
        #1 chk("idle after reset release", {11'b0, act}, {11'b0, 4'd0, outs_for(4'd0, 2'd0)});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lvds_rx_bringup_ctrl.md
LVDS_RX_BRINGUP_CTRL -- requirements
Module: lvds_rx_bringup_ctrl

Interface
REQ-001 Parameters SHALL be:
  NCH, 4, number of LVDS receive channels
  PLL_RST_CYCLES, 8, pll_areset hold time in cycles
  LOCK_STABLE_CYCLES, 20, consecutive synced rx_locked-high cycles required
  TIMEOUT_CYCLES, 1024, max cycles in any wait state
  MAX_RETRIES, 3, failed attempts before FAIL
REQ-002 Ports SHALL be:
  inclock  in  1  sole clock
  areset_n  in  1  asynchronous active-low reset
  start  in  1  begin or re-begin bring-up
  rx_locked  in  1  LVDS PLL lock, asynchronous
  rx_dpa_locked  in  NCH  per-channel DPA lock, asynchronous
  pll_areset  out  1  PLL reset
  rx_reset  out  NCH  per-channel receiver reset
  rx_fifo_reset  out  NCH  per-channel FIFO reset pulse
  rx_cda_reset  out  NCH  per-channel clock-data-alignment reset pulse
  link_ready  out  1  bring-up complete
  init_fail  out  1  retries exhausted
  retry_cnt  out  2  failed attempts in the current run
  state  out  4  current FSM state

Function
REQ-003 All outputs SHALL be registered Moore outputs decoded from the state, with no combinational input-to-output path.
REQ-004 rx_locked and rx_dpa_locked SHALL each pass through a 2-flop synchronizer; "synced" below means the synchronizer output, which is 2 cycles late.
REQ-005 States SHALL be IDLE, PLL_RST, WAIT_LOCK, LOCK_STABLE, WAIT_DPA, FIFO_RST, CDA_RST, READY, FAIL.
REQ-006 Outputs per state SHALL be as follows; unlisted outputs are 0:
  IDLE, PLL_RST, FAIL: pll_areset=1, rx_reset all 1
  WAIT_LOCK, LOCK_STABLE: rx_reset all 1
  FIFO_RST: rx_fifo_reset all 1
  CDA_RST: rx_cda_reset all 1
  READY: link_ready=1
  FAIL: init_fail=1
REQ-007 IDLE SHALL move to PLL_RST on start=1, and SHALL clear retry_cnt when it does.
REQ-008 PLL_RST SHALL last exactly PLL_RST_CYCLES cycles, then move to WAIT_LOCK.
REQ-009 On entry to WAIT_LOCK, WAIT_DPA and LOCK_STABLE, the cycle timer SHALL clear.
REQ-010 WAIT_LOCK SHALL move to LOCK_STABLE on synced rx_locked=1.
REQ-011 LOCK_STABLE SHALL return to WAIT_LOCK if synced rx_locked=0 before LOCK_STABLE_CYCLES consecutive high cycles, and move to WAIT_DPA after that count.
REQ-012 WAIT_DPA SHALL move to FIFO_RST when all NCH synced rx_dpa_locked bits are 1.
REQ-013 FIFO_RST and CDA_RST SHALL each last exactly 1 cycle, in that order, and CDA_RST SHALL then move to READY.
REQ-014 A failed attempt is either of:
  timer reaching TIMEOUT_CYCLES in WAIT_LOCK or WAIT_DPA
  synced rx_locked=0 in WAIT_DPA, FIFO_RST or CDA_RST
REQ-015 On a failed attempt retry_cnt SHALL increment (saturating), then:
  if retry_cnt+1 == MAX_RETRIES, go to FAIL
  otherwise go to PLL_RST
REQ-016 In READY, synced rx_locked=0 SHALL clear retry_cnt and go to PLL_RST, so link_ready drops the next cycle.
REQ-017 FAIL SHALL hold until start=1, then clear retry_cnt and go to PLL_RST.
REQ-018 start SHALL be ignored in every state except IDLE and FAIL.
REQ-019 When a timeout and a lock-loss condition occur in the same cycle, the result SHALL be a single failed attempt, counted once.
REQ-020 The timer SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, saturating and never wrapping.

Reset
REQ-021 On areset_n=0, asynchronously:
  state = IDLE
  pll_areset = 1, rx_reset = all 1
  every other output = 0
  timer, counters and synchronizers cleared
REQ-022 Reset asserted mid-sequence SHALL abort immediately with no pulse completion; after deassertion the block SHALL wait in IDLE for start.

Structure
REQ-023 Package lvds_rx_pkg SHALL hold:
  state enum typedef (4-bit)
  default parameter constants
REQ-024 The 2-flop synchronizer SHALL be a separate sub-module, lvds_sync2, parameterized by width, with asynchronous active-low clear.

Verification
REQ-025 The bench SHALL cover these directed scenarios, with default parameters:
  1. start at cycle 10, rx_locked=1 from cycle 30, rx_dpa_locked=4'hF from cycle 100 -> pll_areset high 8 cycles after the PLL_RST entry; rx_reset drops 20+2 cycles after rx_locked; one-cycle rx_fifo_reset then one-cycle rx_cda_reset; link_ready=1 and stays.
  2. rx_locked glitches low for 1 cycle after 10 stable cycles -> returns to WAIT_LOCK, stable count restarts, full 20 cycles required.
  3. rx_dpa_locked stuck at 4'h7 -> 3 timeouts of 1024 cycles with retry_cnt 1, 2 -> FAIL, init_fail=1, pll_areset=1; start then restarts with retry_cnt=0.
  4. rx_locked drops in READY -> link_ready=0 next cycle, pll_areset=1, full sequence repeats.
  5. areset_n pulsed low during FIFO_RST -> rx_fifo_reset=0 immediately, all REQ-021 values, IDLE.
